pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register. Successor to the fixed-width decode/execute buffer.
- Carries NUM_OPS data operands, the instruction word and a control bundle from one pipeline stage to the next.
- Adds a valid/ready handshake, stall, flush and bubble masking. The mode parameter selects a single register or a two-entry skid buffer with a registered ready.
- Instantiated between every pair of CPU stages (ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 16, width of each operand lane
- NUM_OPS, 3, number of operand lanes (e.g. ALU in1, ALU in2, op1 store data)
- INSTR_W, 16, instruction word width
- CTRL_W, 8, control bundle width (aluOp, mux selects, r0 write, reg write, mem write enable)
- SKID, 1, 0 = single register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all held and incoming entries (branch taken / exception)
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_ops  in  NUM_OPS*DATA_W  operand lanes; lane k at bits [k*DATA_W +: DATA_W]
- in_instr  in  INSTR_W  instruction word
- in_ctrl  in  CTRL_W  control bundle
- out_valid  out  1  output entry present
- out_ready  in  1  downstream accepts (0 = stall)
- out_ops  out  NUM_OPS*DATA_W  registered operands
- out_instr  out  INSTR_W  registered instruction
- out_ctrl  out  CTRL_W  registered control, forced to 0 when out_valid=0
- count  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1)

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is rst_n, synchronous and active-low. Everything updates only on rising clk.
  - Reset has priority over flush and all transfers.
  - Reset values: out_valid=0, out_ops=0, out_instr=0, out_ctrl=0, count=0. For SKID=1, in_ready resets to 1.
  - Inputs are ignored on any edge where rst_n=0.
- Transfer rules:
  - Input transfer = in_valid & in_ready at the edge.
  - Output transfer = out_valid & out_ready at the edge.
- Bubble masking:
  - out_ctrl = held ctrl & {CTRL_W{out_valid}}. A bubble never asserts a register or memory write enable.
  - out_ops and out_instr hold their last value when invalid; verification does not check them.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Latency 1 cycle. Full throughput when out_ready=1.
  - With out_ready=0 and out_valid=1, the register holds.
- SKID=1:
  - Two slots: main (drives outputs) and skid.
  - in_ready is a flop equal to (skid slot empty).
  - States, encoded by count:
    - EMPTY (0): input transfer -> ONE.
    - ONE (1):
      - input and output together -> ONE, main gets new entry.
      - input only (stall) -> TWO, new entry goes to skid.
      - output only -> EMPTY.
    - TWO (2): in_ready=0.
      - output transfer -> ONE, skid moves to main.
      - otherwise hold.
  - Latency in->out 1 cycle. Throughput 1/cycle sustained with out_ready=1. No combinational path from out_ready to in_ready.
- Flush:
  - flush=1 at an edge (rst_n=1): count->0, out_valid->0, in_ready->1 (SKID=1).
  - Any input transfer on that edge is discarded.
  - A downstream output transfer on that edge still counts as completed.
- Order: entries leave in arrival order. No drop or duplication except by flush.
- count mirrors state and never exceeds 1 (SKID=0) or 2 (SKID=1).

Decomposition:
- Shared package pipe_pkg:
  - CTRL field offsets/widths (ALUOP_LSB, ALUOP_W=4, MUX3SEL_BIT, R0WR_BIT, REGWR_BIT, WEN_BIT)
  - DATA_W and INSTR_W defaults
  - Helper constant PAYLOAD_W = NUM_OPS*DATA_W + INSTR_W + CTRL_W
- Sub-module pipe_slot: one payload register with load enable and valid flop. Instantiated once for SKID=0, twice (main, skid) for SKID=1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, count=0; after release, in_ready=1.
- Streaming, SKID=1: send instr 16'h1001..16'h1008 back-to-back with out_ready=1 -> out_instr shows 1001..1008 on consecutive cycles, 1 cycle after each input; count stays 1.
- Stall fill: out_ready=0, send 16'hA000 then 16'hA001 -> count=2, in_ready=0, 16'hA002 held upstream; raise out_ready -> A000, A001, A002 emerge in order with no loss.
- Flush with simultaneous input: count=2, flush=1 with in_valid=1 (instr 16'hBEEF) -> next cycle out_valid=0, count=0, out_ctrl=0, in_ready=1; BEEF never appears.
- Bubble masking: in_ctrl=8'h5A then in_valid=0 for 3 cycles with out_ready=1 -> out_ctrl=8'h5A for one cycle, then 0 while out_valid=0.
- SKID=0 variant: out_valid=1 with out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> in_ready=1 and the register reloads every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: control bundle
// field layout, default widths, buffer occupancy states and a payload width helper.
package pipe_pkg;

  localparam int DATA_W_DEFAULT  = 16;
  localparam int INSTR_W_DEFAULT = 16;
  localparam int CTRL_W_DEFAULT  = 8;

  // Control bundle layout: aluOp in the low nibble, then single-bit enables.
  localparam int ALUOP_LSB   = 0;
  localparam int ALUOP_W     = 4;
  localparam int MUX3SEL_BIT = 4;
  localparam int R0WR_BIT    = 5;
  localparam int REGWR_BIT   = 6;
  localparam int WEN_BIT     = 7;

  // Occupancy of the two-entry skid buffer; the encoding is the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } slot_state_e;

  // Total width of one packed entry {ops, instr, ctrl}.
  function automatic int payload_w(input int num_ops, input int data_w,
                                   input int instr_w, input int ctrl_w);
    return num_ops * data_w + instr_w + ctrl_w;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a payload register with load enable plus its valid flop.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         valid_d,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Valid follows its next-state every cycle; payload only moves on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= valid_d;
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// flush and bubble masking. SKID selects a single register or a two-entry
// skid buffer whose in_ready comes straight from a flop.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int NUM_OPS = 3,
  parameter int INSTR_W = INSTR_W_DEFAULT,
  parameter int CTRL_W  = CTRL_W_DEFAULT,
  parameter int SKID    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [INSTR_W-1:0]        in_instr,
  input  logic [CTRL_W-1:0]         in_ctrl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [1:0]                count
);

  localparam int OPS_W     = NUM_OPS * DATA_W;
  localparam int PAYLOAD_W = payload_w(NUM_OPS, DATA_W, INSTR_W, CTRL_W);

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] main_q;
  logic                 main_valid;
  logic                 in_xfer;
  logic                 out_xfer;

  assign in_payload = {in_ops, in_instr, in_ctrl};
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = main_valid & out_ready;

  // The main slot always drives the outputs; a bubble never carries control.
  assign out_valid = main_valid;
  assign out_ops   = main_q[PAYLOAD_W-1 -: OPS_W];
  assign out_instr = main_q[CTRL_W +: INSTR_W];
  assign out_ctrl  = main_q[CTRL_W-1:0] & {CTRL_W{main_valid}};

  if (SKID != 0) begin : g_skid
    slot_state_e          state_q;
    slot_state_e          state_d;
    logic                 main_load;
    logic                 skid_load;
    logic                 main_from_skid;
    logic                 skid_valid;
    logic [PAYLOAD_W-1:0] skid_q;
    logic [PAYLOAD_W-1:0] main_d;

    // Next occupancy and slot loads; flush empties both slots and drops input.
    always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              state_d   = ST_ONE;
              main_load = 1'b1;
            end
          end
          ST_ONE: begin
            if (in_xfer && out_xfer) begin
              main_load = 1'b1;
            end else if (in_xfer) begin
              state_d   = ST_TWO;
              skid_load = 1'b1;
            end else if (out_xfer) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_xfer) begin
              state_d        = ST_ONE;
              main_load      = 1'b1;
              main_from_skid = 1'b1;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    assign main_d = main_from_skid ? skid_q : in_payload;

    pipe_slot #(.W(PAYLOAD_W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (main_load),
      .valid_d (state_d != ST_EMPTY),
      .d       (main_d),
      .q       (main_q),
      .valid   (main_valid)
    );

    pipe_slot #(.W(PAYLOAD_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (skid_load),
      .valid_d (state_d == ST_TWO),
      .d       (in_payload),
      .q       (skid_q),
      .valid   (skid_valid)
    );

    // Ready is the registered "skid empty" flag, so out_ready never reaches it.
    assign in_ready = ~skid_valid;
    assign count    = state_q;
  end else begin : g_single
    logic valid_d;

    // Single register: a new entry replaces the old one, flush clears it.
    always_comb begin
      valid_d = main_valid;
      if (flush) begin
        valid_d = 1'b0;
      end else if (in_xfer) begin
        valid_d = 1'b1;
      end else if (out_xfer) begin
        valid_d = 1'b0;
      end
    end

    pipe_slot #(.W(PAYLOAD_W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (in_xfer & ~flush),
      .valid_d (valid_d),
      .d       (in_payload),
      .q       (main_q),
      .valid   (main_valid)
    );

    assign in_ready = out_ready | ~main_valid;
    assign count    = {1'b0, main_valid};
  end

endmodule
